// File: rtl/mem_bank_arbiter_pkg.sv
// Shared types for the memory-bank arbiter: the datapath-to-memory packet
// and the arbiter FSM state encoding.
package mem_bank_arbiter_pkg;

  localparam int packet_size = 8;
  localparam int Num_Edge_PE = 4;

  typedef struct packed {
    logic                   valid;
    logic [packet_size-1:0] packet;
  } DP2mem_packet;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_bank_arbiter_rr_select.sv
// Round-robin priority selector: the first asserted request at or after
// rr_ptr, wrapping through index 0, wins and is returned one-hot.
module rr_select #(
  parameter int N_REQ = 4,
  parameter int PW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    rr_ptr,
  output logic [N_REQ-1:0] winner,
  output logic             any
);

  int idx;

  // NOTE: every output gets a default before the search loop so no latch is inferred.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % N_REQ;
      if (req[idx] && !any) begin
        winner[idx] = 1'b1;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_bank_arbiter.sv
// Single-bank memory arbiter: round-robin grant, one packet transfer per
// grant, then a fixed busy window before the next arbitration.
module mem_bank_arbiter
  import mem_bank_arbiter_pkg::*;
#(
  parameter int N_REQ       = Num_Edge_PE,
  parameter int BUSY_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  DP2mem_packet       req_pkt [N_REQ],
  input  logic               mem_stall,
  output logic [N_REQ-1:0]   grant,
  output DP2mem_packet       mem_pkt_out,
  output logic               bank_busy,
  output logic               grant_miss
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t        state;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     win_idx;
  logic [PW-1:0]     sel_idx;
  logic [N_REQ-1:0]  sel_onehot;
  logic              sel_any;
  logic [3:0]        busy_cnt;

  rr_select #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_rr_select (
    .req    (req),
    .rr_ptr (rr_ptr),
    .winner (sel_onehot),
    .any    (sel_any)
  );

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel_onehot[i]) sel_idx = PW'(i);
    end
  end

  // NOTE: all state and outputs update with non-blocking assignments so every
  // register sees pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      grant       <= '0;
      mem_pkt_out <= '0;
      bank_busy   <= 1'b0;
      grant_miss  <= 1'b0;
      rr_ptr      <= '0;
      win_idx     <= '0;
      busy_cnt    <= '0;
    end else begin
      // valid is a single-cycle pulse; the packet field keeps its last value
      mem_pkt_out.valid <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_any && !mem_stall) begin
            grant     <= sel_onehot;
            win_idx   <= sel_idx;
            bank_busy <= 1'b1;
            state     <= GRANT;
          end
        end
        GRANT: begin
          grant  <= '0;
          rr_ptr <= PW'((int'(win_idx) + 1) % N_REQ);
          if (req_pkt[win_idx].valid) begin
            mem_pkt_out <= req_pkt[win_idx];
            busy_cnt    <= 4'(BUSY_CYCLES - 1);
            state       <= BUSY;
          end else begin
            grant_miss <= 1'b1;
            bank_busy  <= 1'b0;
            state      <= IDLE;
          end
        end
        BUSY: begin
          if (busy_cnt == 4'd0) begin
            bank_busy <= 1'b0;
            state     <= IDLE;
          end else begin
            busy_cnt <= busy_cnt - 4'd1;
          end
        end
        default: begin
          grant     <= '0;
          bank_busy <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bank_arbiter.sv
// Directed bench for mem_bank_arbiter: a cycle-by-cycle vector table plus
// hand-written fairness, stall and mid-access reset sequences.
module tb_mem_bank_arbiter;
  import mem_bank_arbiter_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req;
  DP2mem_packet req_pkt [4];
  logic         mem_stall;
  logic [3:0]   grant;
  DP2mem_packet mem_pkt_out;
  logic         bank_busy;
  logic         grant_miss;

  int n_checks = 0;
  int n_errors = 0;

  mem_bank_arbiter #(
    .N_REQ       (4),
    .BUSY_CYCLES (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_pkt     (req_pkt),
    .mem_stall   (mem_stall),
    .grant       (grant),
    .mem_pkt_out (mem_pkt_out),
    .bank_busy   (bank_busy),
    .grant_miss  (grant_miss)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] vld;
    logic       stall;
    logic [3:0] exp_grant;
    logic       exp_busy;
    logic       exp_mvalid;
    logic [7:0] exp_pkt;
    logic       exp_miss;
  } vec_t;

  vec_t vecs [23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Requester i always offers packet 0xA5+i; only its valid bit varies.
  task automatic drive(input logic [3:0] r, input logic [3:0] v, input logic s);
    req       = r;
    mem_stall = s;
    for (int i = 0; i < 4; i++) req_pkt[i] = {v[i], 8'(8'hA5 + i)};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(4'b0000, 4'b0000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset grant", 32'(grant), 32'h0);
    check("reset busy", 32'(bank_busy), 32'h0);
    check("reset pkt", 32'(mem_pkt_out), 32'h0);
    check("reset miss", 32'(grant_miss), 32'h0);
    reset = 1'b1;
  endtask

  initial begin
    int last_cyc;
    int n_grants;
    int n_valid;

    reset = 1'b0;
    drive(4'b0000, 4'b0000, 1'b0);

    //           req      vld      stl   grant    busy  mv    pkt    miss
    vecs[0]  = '{4'b0001, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{4'b0000, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b1, 8'hA5, 1'b0};
    vecs[2]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 8'hA5, 1'b0};
    vecs[3]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 8'hA5, 1'b0};
    vecs[4]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 8'hA5, 1'b0};
    vecs[5]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'hA5, 1'b0};
    // miss on requester 1, with req dropped during the grant cycle
    vecs[6]  = '{4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b1, 1'b0, 8'hA5, 1'b0};
    vecs[7]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'hA5, 1'b1};
    vecs[8]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'hA5, 1'b1};
    // grant 2 moves the pointer to 3
    vecs[9]  = '{4'b0100, 4'b0100, 1'b0, 4'b0100, 1'b1, 1'b0, 8'hA5, 1'b1};
    vecs[10] = '{4'b0000, 4'b0100, 1'b0, 4'b0000, 1'b1, 1'b1, 8'hA7, 1'b1};
    vecs[11] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 8'hA7, 1'b1};
    vecs[12] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 8'hA7, 1'b1};
    vecs[13] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 8'hA7, 1'b1};
    vecs[14] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'hA7, 1'b1};
    // wrap: pointer 3 with req 0101 picks 0, then 2
    vecs[15] = '{4'b0101, 4'b0101, 1'b0, 4'b0001, 1'b1, 1'b0, 8'hA7, 1'b1};
    vecs[16] = '{4'b0101, 4'b0101, 1'b0, 4'b0000, 1'b1, 1'b1, 8'hA5, 1'b1};
    vecs[17] = '{4'b0101, 4'b0101, 1'b0, 4'b0000, 1'b1, 1'b0, 8'hA5, 1'b1};
    vecs[18] = '{4'b0101, 4'b0101, 1'b0, 4'b0000, 1'b1, 1'b0, 8'hA5, 1'b1};
    vecs[19] = '{4'b0101, 4'b0101, 1'b0, 4'b0000, 1'b1, 1'b0, 8'hA5, 1'b1};
    vecs[20] = '{4'b0101, 4'b0101, 1'b0, 4'b0000, 1'b0, 1'b0, 8'hA5, 1'b1};
    vecs[21] = '{4'b0101, 4'b0101, 1'b0, 4'b0100, 1'b1, 1'b0, 8'hA5, 1'b1};
    vecs[22] = '{4'b0000, 4'b0100, 1'b0, 4'b0000, 1'b1, 1'b1, 8'hA7, 1'b1};

    do_reset();
    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].req, vecs[i].vld, vecs[i].stall);
      step();
      check($sformatf("v%0d grant", i), 32'(grant), 32'(vecs[i].exp_grant));
      check($sformatf("v%0d busy", i), 32'(bank_busy), 32'(vecs[i].exp_busy));
      check($sformatf("v%0d mvalid", i), 32'(mem_pkt_out.valid), 32'(vecs[i].exp_mvalid));
      check($sformatf("v%0d pkt", i), 32'(mem_pkt_out.packet), 32'(vecs[i].exp_pkt));
      check($sformatf("v%0d miss", i), 32'(grant_miss), 32'(vecs[i].exp_miss));
    end

    // Fairness: all requesters held, grants 0,1,2,3,0,... six cycles apart.
    do_reset();
    drive(4'b1111, 4'b1111, 1'b0);
    last_cyc = 0;
    n_grants = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      step();
      if (grant != 4'b0000) begin
        check($sformatf("fair grant %0d", n_grants), 32'(grant), 32'(4'b0001 << (n_grants % 4)));
        if (n_grants > 0) check($sformatf("fair gap %0d", n_grants), 32'(cyc - last_cyc), 32'd6);
        last_cyc = cyc;
        n_grants++;
      end
    end
    check("fair count", 32'(n_grants), 32'd7);

    // Stall holds off arbitration only while idle.
    do_reset();
    drive(4'b0001, 4'b0001, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("stall grant %0d", i), 32'(grant), 32'h0);
    end
    drive(4'b0001, 4'b0001, 1'b0);
    step();
    check("unstall grant", 32'(grant), 32'(4'b0001));
    drive(4'b0000, 4'b0001, 1'b1);
    step();
    check("stall in grant mvalid", 32'(mem_pkt_out.valid), 32'h1);
    check("stall in grant pkt", 32'(mem_pkt_out.packet), 32'hA5);
    drive(4'b0000, 4'b0000, 1'b0);
    step();
    check("busy before reset", 32'(bank_busy), 32'h1);

    // Asynchronous reset mid-BUSY clears outputs without waiting for an edge.
    #2;
    reset = 1'b0;
    #1;
    check("async grant", 32'(grant), 32'h0);
    check("async busy", 32'(bank_busy), 32'h0);
    check("async pkt", 32'(mem_pkt_out), 32'h0);
    check("async miss", 32'(grant_miss), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    n_valid = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (mem_pkt_out.valid || bank_busy) n_valid++;
    end
    check("no stray activity", 32'(n_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
